div: RTL and testbench
======================

// Module: div
// PURPOSE
//  Multi-cycle 32-bit divider for DIV/DIVU in the EX stage. It is the requester side of the
//  stall protocol: while a division is in flight it raises stall_req_o into ctrl's ex_stall_i,
//  which freezes PC/IF/ID/EX. It hands {remainder, quotient} to the HI/LO write path when done.
//  Radix-2 restoring algorithm, one quotient bit per cycle.
// PARAMETERS
//  WIDTH    32  operand width; result_o is 2*WIDTH
//  CNT_W    6   iteration counter width; must hold the value WIDTH
// PORTS
//  clk           in   1        rising-edge clock
//  rst_n         in   1        asynchronous, active-low reset
//  signed_div_i  in   1        1 = DIV (signed), 0 = DIVU; sampled on acceptance only
//  opdata1_i     in   WIDTH    dividend; sampled on acceptance only
//  opdata2_i     in   WIDTH    divisor; sampled on acceptance only
//  start_i       in   1        EX holds 1 for as long as it wants a result
//  annul_i       in   1        flush; abandons any operation in flight
//  result_o      out  2*WIDTH  {remainder[63:32] -> HI, quotient[31:0] -> LO}
//  ready_o       out  1        result_o is valid
//  stall_req_o   out  1        to ctrl ex_stall_i; combinational
// BEHAVIOUR
//  - Single clock domain; one asynchronous, active-low reset (rst_n).
//  - Reset (rst_n=0, asynchronous): state=IDLE, cnt=0, result_o=0, ready_o=0.
//  - stall_req_o = start_i & ~annul_i & ~ready_o. No registered delay.
//  - States: IDLE, DIVZERO, ON, END.
//  - IDLE:
//      start_i & ~annul_i & opdata2_i==0 -> DIVZERO.
//      start_i & ~annul_i, nonzero divisor -> ON, cnt=0. Latch |op1| and |op2| when signed,
//      raw operands when unsigned, the signs, and signed_div_i.
//      Otherwise stay in IDLE; ready_o=0, result_o=0.
//  - DIVZERO: after 1 cycle -> END with result_o=0.
//      MIPS leaves this result undefined; ours is fixed at 0.
//  - ON, cycle k (k=0..31):
//      shift the partial remainder left and bring in the next dividend bit (MSB first);
//      trial-subtract the divisor in 33 bits.
//      Non-negative difference: keep it, quotient bit=1. Negative: restore, bit=0.
//      cnt++. When cnt==32 -> END.
//      Sign fix-up on that transition:
//        quotient negated if signed and sign1^sign2;
//        remainder negated if signed and sign1 (remainder takes the dividend's sign).
//  - END: ready_o=1, result_o holds; stays in END while start_i=1.
//      start_i=0 -> IDLE; next cycle ready_o=0, result_o=0.
//  - Latency from the IDLE acceptance edge: 33 cycles to ready_o for a nonzero divisor;
//      2 cycles for a zero divisor. stall_req_o is high for exactly those cycles.
//  - annul_i=1 in any state -> IDLE on the next edge: ready_o=0, result_o=0, cnt=0.
//      annul_i also forces stall_req_o=0 in the same cycle.
//  - start_i dropping in ON or DIVZERO: abandon -> IDLE, identical to annul.
//  - Signed overflow, 0x80000000 / -1: quotient=0x80000000, remainder=0.
//      This falls out of 2's-complement wrap; no special case.
//  - Operands changing after acceptance have no effect on the operation in flight.
//  - Back-to-back divides: an intervening IDLE cycle is mandatory. The pipeline drops
//      start_i on release from END.
// STRUCTURE
//  - defines.vh:
//      state encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2 bits);
//      `DivResultReady`/`DivResultNotReady`, `DivStart`/`DivStop`; `ZeroWord`.
//  - Natural sub-module: div_step. Combinational, one restoring iteration:
//      inputs  {partial remainder, divisor}
//      outputs {next remainder, quotient bit}
//      Instantiated once and reused every cycle.
//  - Top level: FSM, cnt, operand/sign registers, negate-on-exit logic.
// TESTING
//  1. DIVU 100 / 7 -> ready_o at cycle 33; result_o = {32'd2, 32'd14}; stall_req_o high cycles 0-32.
//  2. DIV -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
//     DIV 7 / -2 -> quotient -3, remainder 1.
//  3. Divisor 0 (signed or unsigned) -> ready_o at cycle 2; result_o=0; stall_req_o high 2 cycles.
//  4. annul_i pulsed at cycle 10 of ON -> IDLE at next edge; ready_o never rises; stall_req_o=0
//     that cycle. A fresh 0xFFFFFFFF / 1 DIVU then returns {0, 0xFFFFFFFF}.
//  5. DIV 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}.
//     DIVU 0x80000000 / 0xFFFFFFFF -> {0x80000000, 0}.
//  6. rst_n low mid-ON (async, between edges) -> outputs 0 immediately; state IDLE after release.
//     Random signed/unsigned checks against a $signed / and % reference model.

Source files
------------

// File: rtl/div_pkg.sv
// Shared encodings for the multi-cycle divider: FSM states and ready/start levels.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: trial-subtract the divisor from the shifted partial remainder.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   partial_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic signed [WIDTH:0] diff;

  // The partial remainder is always below 2*divisor, so the difference fits WIDTH+1 signed bits.
  assign diff    = $signed(partial_i - {1'b0, divisor_i});
  assign q_bit_o = ~diff[WIDTH];
  assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : partial_i[WIDTH-1:0];

endmodule

// File: rtl/div.sv
// Multi-cycle DIV/DIVU unit for EX: restoring divider with stall request and {rem, quo} result.
module div
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_req_o
);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sign1_q, sign1_d;
  logic               sign2_q, sign2_d;
  logic               sgn_q, sgn_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic [WIDTH-1:0]   step_rem;
  logic               step_bit;
  logic [WIDTH-1:0]   quo_next;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return en ? $unsigned(-sv) : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .partial_i ({rem_q, dvd_q[WIDTH-1]}),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  // The dividend register shifts out MSB-first while quotient bits shift in at the bottom.
  assign quo_next    = {dvd_q[WIDTH-2:0], step_bit};
  assign stall_req_o = start_i & ~annul_i & ~ready_q;
  assign result_o    = result_q;
  assign ready_o     = ready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    sgn_d    = sgn_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d = DivOn;
            cnt_d   = '0;
            rem_d   = '0;
            sign1_d = opdata1_i[WIDTH-1];
            sign2_d = opdata2_i[WIDTH-1];
            sgn_d   = signed_div_i;
            dvd_d   = neg_if(opdata1_i, signed_div_i & opdata1_i[WIDTH-1]);
            dvs_d   = neg_if(opdata2_i, signed_div_i & opdata2_i[WIDTH-1]);
          end
        end
      end
      DivByZero: begin
        if (start_i) begin
          state_d  = DivEnd;
          ready_d  = DivResultReady;
          result_d = '0;
        end else begin
          state_d = DivFree;
          cnt_d   = '0;
        end
      end
      DivOn: begin
        if (start_i) begin
          rem_d = step_rem;
          dvd_d = quo_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DivEnd;
            ready_d  = DivResultReady;
            result_d = {neg_if(step_rem, sgn_q & sign1_q),
                        neg_if(quo_next, sgn_q & (sign1_q ^ sign2_q))};
          end
        end else begin
          state_d = DivFree;
          cnt_d   = '0;
        end
      end
      default: begin
        if (!start_i) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
          cnt_d    = '0;
        end
      end
    endcase
    if (annul_i) begin
      state_d  = DivFree;
      ready_d  = DivResultNotReady;
      result_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q   <= rem_d;
    dvd_q   <= dvd_d;
    dvs_q   <= dvs_d;
    sign1_q <= sign1_d;
    sign2_q <= sign2_d;
    sgn_q   <= sgn_d;
  end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: expected {rem, quo} queued at issue, popped on each ready_o rise.
module tb_div;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           signed_div = 1'b0;
  logic           start = 1'b0;
  logic           annul = 1'b0;
  logic [W-1:0]   op1 = '0;
  logic [W-1:0]   op2 = '0;
  logic [2*W-1:0] result;
  logic           ready;
  logic           stall;

  int             n_cmp = 0;
  int             n_fail = 0;
  logic [63:0]    exp_q[$];
  logic           rdy_prev = 1'b0;

  always #5 clk = ~clk;

  div #(.WIDTH(W), .CNT_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stall_req_o  (stall)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer division, truncating toward zero; divide-by-zero yields 0.
  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: every rising ready_o must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ready && !rdy_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_ready: got result %h with no outstanding op", result);
        end else begin
          check("result", result, exp_q.pop_front());
        end
      end
      rdy_prev = ready;
    end
  end

  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    int st;
    int exp_lat;
    cyc = 0;
    st = 0;
    exp_lat = (b == 32'd0) ? 2 : 33;
    exp_q.push_back(ref_div(sg, a, b));
    signed_div = sg;
    op1 = a;
    op2 = b;
    start = 1'b1;
    #1;
    if (stall) st++;
    while (!ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (stall) st++;
      op1 = $urandom;
      op2 = $urandom;
      signed_div = 1'($urandom_range(0, 1));
    end
    if (!ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: ready_o never rose for %h / %h", a, b);
    end
    check("latency", 64'(cyc), 64'(exp_lat));
    check("stall_cycles", 64'(st), 64'(exp_lat));
    start = 1'b0;
    @(negedge clk);
    check("release_ready", {63'd0, ready}, 64'd0);
    check("release_result", result, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    int cyc;
    repeat (3) @(negedge clk);
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_stall", {63'd0, stall}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_div(1'b0, 32'd100, 32'd7);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE);
    do_div(1'b0, 32'd1234, 32'd0);
    do_div(1'b1, 32'h8000_0000, 32'd0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

    // Annul mid-operation, then immediately issue a fresh divide while start stays high.
    signed_div = 1'b0;
    op1 = 32'd500;
    op2 = 32'd3;
    start = 1'b1;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    #1;
    check("annul_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    check("annul_ready", {63'd0, ready}, 64'd0);
    annul = 1'b0;
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1);

    // Dropping start mid-operation abandons it; no ready may follow.
    op1 = 32'd999;
    op2 = 32'd5;
    start = 1'b1;
    repeat (6) @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("abandon_ready", {63'd0, ready}, 64'd0);

    // Asynchronous reset while holding a result in END.
    exp_q.push_back(ref_div(1'b0, 32'd100, 32'd7));
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    cyc = 0;
    while (!ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("pre_reset_ready", {63'd0, ready}, 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_ready", {63'd0, ready}, 64'd0);
    check("async_reset_result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-ON, then a normal divide from IDLE.
    @(negedge clk);
    op1 = 32'd77;
    op2 = 32'd9;
    start = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_on_reset_ready", {63'd0, ready}, 64'd0);
    check("mid_on_reset_result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle", {63'd0, ready}, 64'd0);
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 9) == 0) b = 32'd0;
      else if ($urandom_range(0, 1) == 1) b = $urandom;
      else b = 32'($urandom_range(1, 1000));
      do_div(1'($urandom_range(0, 1)), a, b);
    end

    @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
